uart_trx: RTL and testbench
===========================

# uart_trx

Parametrised full-duplex UART transceiver; successor to the fixed 8N1 transmit/receive pair. One instance provides a transmit path and a receive path on separate pins. Data width, baud divisor, parity mode and stop-bit count are set by parameters. The receiver detects parity errors, framing errors, overruns and false start bits. It sits between the host command/telemetry logic and the board serial pins.

## Interface
- `DATA_W`, default 8: data bits per frame; legal values 5..9.
- `BAUD_DIV`, default 2604: clk cycles per bit. Legal range is ≥ 16; 50 MHz / 19200 gives 2604.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk  in  1`: sole clock; every flop is on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `trmt  in  1`: one-cycle pulse; starts transmission of `tx_data`.
- `tx_data  in  DATA_W`: sampled on the cycle `trmt` is high.
- `TX  out  1`: serial output; idles high.
- `tx_done  out  1`: high once the last stop bit finishes; cleared by the next `trmt`.
- `RX  in  1`: asynchronous serial input.
- `rx_data  out  DATA_W`: last accepted frame, LSB first on the wire.
- `rdy  out  1`: a new frame is held in `rx_data`.
- `clr_rdy  in  1`: clears `rdy`, `parity_err`, `frame_err` and `overrun`.
- `parity_err  out  1`: the held frame had a bad parity bit.
- `frame_err  out  1`: a stop bit of the held frame sampled low.
- `overrun  out  1`: a frame completed while `rdy` was still set.

## Operation
- **Reset values:** `TX`=1, `tx_done`=0, `rx_data`=0, `rdy`=0, all error flags 0; both FSMs go to IDLE.
- **TX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - A `trmt` in IDLE latches `tx_data` into the shift register and clears `tx_done`.
  - Bits go out LSB first; each bit lasts exactly `BAUD_DIV` cycles.
  - The parity bit is XOR of the data bits for even mode, inverted for odd mode. The PARITY state is skipped when `PARITY`=0.
  - STOP holds `TX` high for `STOP_BITS`×`BAUD_DIV` cycles, then sets `tx_done`.
  - `trmt` in any non-IDLE state is ignored.
- **RX front end:** `RX` passes through a two-flop synchroniser, with the first flop reset to 1.
- **RX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - A falling edge on the synchronised input in IDLE enters START.
  - The line is sampled at `BAUD_DIV/2` (integer division) into START. If it is high again, this is a false start: return to IDLE with no flag change.
  - All later samples are taken `BAUD_DIV` cycles apart. Data shifts in LSB first.
  - The parity bit is compared with the expected value. Each stop bit is sampled; any low stop bit marks a frame error.
- **Frame completion** happens at the mid-point sample of the last stop bit:
  - If `rdy`=0: load `rx_data`, set `rdy`, and load `parity_err`/`frame_err` for this frame.
  - If `rdy`=1: the new frame is discarded, `overrun` is set, and `rx_data` and the other flags are unchanged.
- `clr_rdy` on the same cycle as frame completion: completion wins. `rdy` stays 1 with the new data, and no overrun is flagged.
- The RX FSM returns to IDLE at the stop-bit sample, not at the end of the stop bit, so back-to-back frames are received.
- A `rst` mid-frame aborts both FSMs. `TX` is forced high on the same edge, and any partial RX frame is dropped.

## Timing
- `trmt` sampled at edge N: `TX` goes low at edge N+1.
- Frame length is F = 1 + `DATA_W` + (`PARITY`≠0) + `STOP_BITS` bits.
- `tx_done` rises `F`×`BAUD_DIV` cycles after `TX` fell.
- RX latency from the `RX` falling edge to `rdy` is 2 synchroniser cycles + `BAUD_DIV/2` + (F−1)×`BAUD_DIV` cycles, ±1.
- `clr_rdy` at edge N: `rdy` and the flags are 0 after edge N.
- The baud counter counts 0..`BAUD_DIV`−1 and wraps. Its width is `$clog2(BAUD_DIV)`. The bit counter width is `$clog2(DATA_W+1)`.

## Structure
- `uart_pkg` holds:
  - the parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - typedef enums `tx_state_t` and `rx_state_t`.
- Sub-module `uart_baud_gen`: a loadable down-counter with a `clr` input and a one-cycle `tick` output. It is instantiated once for TX and once for RX; the RX instance is loaded with `BAUD_DIV/2` at start detect.

## Test plan
1. Defaults with `TX` looped to `RX`; send 0x55, then 0xF0, then 0x0F → each gives `rdy`=1, `rx_data` equal to the byte sent, `tx_done`=1, no error flags.
2. `DATA_W`=7, `PARITY`=1, `STOP_BITS`=2, `BAUD_DIV`=16; send 0x5A → `TX` waveform is 0,0,1,0,1,1,0,1,0,1,1, each bit 16 cycles; receiver returns 0x5A with `parity_err`=0.
3. Drive `RX` directly with 0x33 and a flipped parity bit → `parity_err`=1. Drive a frame whose stop bit is low → `frame_err`=1.
4. Send two frames without `clr_rdy` → `overrun`=1 and `rx_data` still holds frame 1. Then pulse `clr_rdy` → all flags 0.
5. Pulse `RX` low for `BAUD_DIV/4` cycles → `rdy` stays 0 and the FSM returns to IDLE. A valid 0xA5 sent afterwards is received correctly.
6. Assert `rst` mid-transmission of 0xC3 → `TX`=1 and `tx_done`=0 on the next edge. A fresh `trmt` then completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants and FSM state types shared by the UART transceiver.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: loadable baud down-counter emitting a one-cycle tick when it reaches zero.
module uart_baud_gen #(
  parameter int BAUD_DIV = 2604,
  localparam int CW = $clog2(BAUD_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  output logic          tick
);
  localparam logic [CW-1:0] TOP = CW'(BAUD_DIV - 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || (clr && !ld)) r_cnt <= TOP;
    else if (ld) r_cnt <= ld_val;
    else r_cnt <= (r_cnt == '0) ? TOP : r_cnt - 1'b1;
  assign tick = (r_cnt == '0) && !clr && !ld;
endmodule

// File: rtl/uart_trx.sv
// uart_trx: parametrised full-duplex UART with parity, 1/2 stop bits and RX error detection.
module uart_trx
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BAUD_DIV  = 2604,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trmt,
  input  logic [DATA_W-1:0] tx_data,
  output logic              TX,
  output logic              tx_done,
  input  logic              RX,
  output logic [DATA_W-1:0] rx_data,
  output logic              rdy,
  input  logic              clr_rdy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_D = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] HALF   = CW'(BAUD_DIV / 2);
  localparam bit   PAR_EN = (PARITY != PAR_NONE);
  localparam logic ODD    = (PARITY == PAR_ODD);

  tx_state_t         r_tx_st;
  logic [DATA_W-1:0] r_tx_sh;
  logic [BW-1:0]     r_tx_bit;
  logic              r_tx_par;
  logic              w_tx_tick;

  rx_state_t         r_rx_st;
  logic [DATA_W-1:0] r_rx_sh;
  logic [BW-1:0]     r_rx_bit;
  logic              r_s1, r_s2, r_s3, r_perr, r_ferr;
  logic              w_rx_tick, w_fall, w_rx_ld;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_tx_baud (
    .clk(clk), .rst(rst), .clr(r_tx_st == TX_IDLE), .ld(1'b0), .ld_val('0), .tick(w_tx_tick)
  );

  always_ff @(posedge clk)
    if (rst) begin
      r_tx_st  <= TX_IDLE;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
      r_tx_sh  <= '0;
      r_tx_bit <= '0;
      r_tx_par <= 1'b0;
    end else case (r_tx_st)
      TX_IDLE: if (trmt) begin
        r_tx_sh  <= tx_data;
        r_tx_par <= ^tx_data ^ ODD;
        tx_done  <= 1'b0;
        TX       <= 1'b0;
        r_tx_st  <= TX_START;
      end
      TX_START: if (w_tx_tick) begin
        TX       <= r_tx_sh[0];
        r_tx_sh  <= r_tx_sh >> 1;
        r_tx_bit <= '0;
        r_tx_st  <= TX_DATA;
      end
      TX_DATA: if (w_tx_tick) begin
        r_tx_bit <= (r_tx_bit == LAST_D) ? '0 : r_tx_bit + 1'b1;
        if (r_tx_bit != LAST_D) begin
          TX      <= r_tx_sh[0];
          r_tx_sh <= r_tx_sh >> 1;
        end else if (PAR_EN) begin
          TX      <= r_tx_par;
          r_tx_st <= TX_PARITY;
        end else begin
          TX      <= 1'b1;
          r_tx_st <= TX_STOP;
        end
      end
      TX_PARITY: if (w_tx_tick) begin
        TX      <= 1'b1;
        r_tx_st <= TX_STOP;
      end
      TX_STOP: if (w_tx_tick) begin
        r_tx_bit <= r_tx_bit + 1'b1;
        if (r_tx_bit == LAST_S) begin
          tx_done <= 1'b1;
          r_tx_st <= TX_IDLE;
        end
      end
      default: r_tx_st <= TX_IDLE;
    endcase

  // The RX counter is preloaded with half a bit so every later tick lands mid-bit.
  assign w_fall  = r_s3 & ~r_s2;
  assign w_rx_ld = (r_rx_st == RX_IDLE) & w_fall;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_rx_baud (
    .clk(clk), .rst(rst), .clr(r_rx_st == RX_IDLE), .ld(w_rx_ld), .ld_val(HALF), .tick(w_rx_tick)
  );

  always_ff @(posedge clk)
    if (rst) begin
      r_s1       <= 1'b1;
      r_s2       <= 1'b1;
      r_s3       <= 1'b1;
      r_rx_st    <= RX_IDLE;
      r_rx_sh    <= '0;
      r_rx_bit   <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      rx_data    <= '0;
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_s1 <= RX;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (clr_rdy) begin
        rdy        <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
      case (r_rx_st)
        RX_IDLE: if (w_fall) r_rx_st <= RX_START;
        RX_START: if (w_rx_tick) begin
          if (r_s2) r_rx_st <= RX_IDLE;
          else begin
            r_rx_bit <= '0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_rx_st  <= RX_DATA;
          end
        end
        RX_DATA: if (w_rx_tick) begin
          r_rx_sh  <= {r_s2, r_rx_sh[DATA_W-1:1]};
          r_rx_bit <= (r_rx_bit == LAST_D) ? '0 : r_rx_bit + 1'b1;
          if (r_rx_bit == LAST_D) begin
            if (PAR_EN) r_rx_st <= RX_PARITY;
            else r_rx_st <= RX_STOP;
          end
        end
        RX_PARITY: if (w_rx_tick) begin
          r_perr  <= r_s2 ^ (^r_rx_sh) ^ ODD;
          r_rx_st <= RX_STOP;
        end
        RX_STOP: if (w_rx_tick) begin
          r_ferr   <= r_ferr | ~r_s2;
          r_rx_bit <= r_rx_bit + 1'b1;
          if (r_rx_bit == LAST_S) begin
            r_rx_st <= RX_IDLE;
            if (!rdy || clr_rdy) begin
              rx_data    <= r_rx_sh;
              rdy        <= 1'b1;
              parity_err <= r_perr;
              frame_err  <= r_ferr | ~r_s2;
            end else overrun <= 1'b1;
          end
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_trx.sv
// tb_uart_trx: scoreboard bench for uart_trx with an 8N1 and a 7E2 instance.
`timescale 1ns/1ps
module tb_uart_trx;
  import uart_pkg::*;
  localparam int BA = 32;
  localparam int BB = 16;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic a_trmt = 0, a_loop = 1, a_drv = 1, a_clr = 0;
  logic a_tx, a_done, a_rx, a_rdy, a_perr, a_ferr, a_ovr;
  logic [7:0] a_txd = '0, a_rxd;
  logic b_trmt = 0, b_loop = 1, b_drv = 1, b_clr = 0;
  logic b_tx, b_done, b_rx, b_rdy, b_perr, b_ferr, b_ovr;
  logic [6:0] b_txd = '0, b_rxd;

  assign a_rx = a_loop ? a_tx : a_drv;
  assign b_rx = b_loop ? b_tx : b_drv;

  uart_trx #(.DATA_W(8), .BAUD_DIV(BA), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .trmt(a_trmt), .tx_data(a_txd), .TX(a_tx), .tx_done(a_done),
    .RX(a_rx), .rx_data(a_rxd), .rdy(a_rdy), .clr_rdy(a_clr),
    .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr));

  uart_trx #(.DATA_W(7), .BAUD_DIV(BB), .PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .trmt(b_trmt), .tx_data(b_txd), .TX(b_tx), .tx_done(b_done),
    .RX(b_rx), .rx_data(b_rxd), .rdy(b_rdy), .clr_rdy(b_clr),
    .parity_err(b_perr), .frame_err(b_ferr), .overrun(b_ovr));

  int n_cmp = 0, n_err = 0;
  logic [9:0] qa[$], qb[$];
  logic a_prev = 0, b_prev = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected entries are {parity_err, frame_err, data}.
  always @(negedge clk) begin : mon_a
    logic [9:0] e;
    if (a_rdy && !a_prev) begin
      if (qa.size() == 0) chk("a_unexpected_rdy", 32'(qa.size()), 1);
      else begin
        e = qa.pop_front();
        chk("a_rx_data", 32'(a_rxd), 32'(e[7:0]));
        chk("a_parity_err", 32'(a_perr), 32'(e[9]));
        chk("a_frame_err", 32'(a_ferr), 32'(e[8]));
      end
    end
    a_prev = a_rdy;
  end

  always @(negedge clk) begin : mon_b
    logic [9:0] e;
    if (b_rdy && !b_prev) begin
      if (qb.size() == 0) chk("b_unexpected_rdy", 32'(qb.size()), 1);
      else begin
        e = qb.pop_front();
        chk("b_rx_data", 32'(b_rxd), 32'(e[6:0]));
        chk("b_parity_err", 32'(b_perr), 32'(e[9]));
        chk("b_frame_err", 32'(b_ferr), 32'(e[8]));
      end
    end
    b_prev = b_rdy;
  end

  task automatic wait_done(input bit b, input string nm);
    int i = 0;
    while (!(b ? b_done : a_done) && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk(nm, 32'(b ? b_done : a_done), 1);
  endtask

  task automatic send_a(input logic [7:0] d, input bit exp_rx);
    if (exp_rx) qa.push_back({2'b00, d});
    @(negedge clk);
    a_trmt = 1;
    a_txd  = d;
    @(negedge clk);
    a_trmt = 0;
    wait_done(0, "a_tx_done");
  endtask

  task automatic clr_a;
    @(negedge clk) a_clr = 1;
    @(negedge clk) a_clr = 0;
    chk("a_rdy_cleared", 32'(a_rdy), 0);
  endtask

  task automatic clr_b;
    @(negedge clk) b_clr = 1;
    @(negedge clk) b_clr = 0;
    chk("b_rdy_cleared", 32'(b_rdy), 0);
  endtask

  task automatic drive(input bit b, input logic [15:0] v, input int n, input int bd);
    for (int i = 0; i < n; i++) begin
      if (b) b_drv = v[i];
      else a_drv = v[i];
      tick(bd);
    end
    a_drv = 1;
    b_drv = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] t1[3];
    logic [10:0] w;
    int i;
    t1 = '{8'h55, 8'hF0, 8'h0F};
    tick(3);
    chk("a_tx_reset", 32'(a_tx), 1);
    chk("a_done_reset", 32'(a_done), 0);
    chk("a_rxd_reset", 32'(a_rxd), 0);
    chk("a_rdy_reset", 32'(a_rdy), 0);
    chk("a_flags_reset", 32'({a_perr, a_ferr, a_ovr}), 0);
    chk("b_tx_reset", 32'(b_tx), 1);
    chk("b_flags_reset", 32'({b_rdy, b_perr, b_ferr, b_ovr}), 0);
    rst = 0;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      send_a(t1[k], 1);
      tick(2);
      clr_a();
    end
    qb.push_back({2'b00, 1'b0, 7'h5A});
    @(negedge clk);
    b_trmt = 1;
    b_txd  = 7'h5A;
    @(negedge clk);
    b_trmt = 0;
    i = 0;
    while (b_tx && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("b_tx_start_low", 32'(b_tx), 0);
    for (int k = 0; k < 11; k++) begin
      tick(k == 0 ? BB / 2 : BB);
      w[k] = b_tx;
    end
    chk("b_tx_wave", 32'(w), 32'(11'b11010110100));
    tick(BB / 2 - 1);
    chk("b_done_not_early", 32'(b_done), 0);
    tick(1);
    chk("b_done_on_time", 32'(b_done), 1);
    tick(2);
    clr_b();
    b_loop = 0;
    qb.push_back({1'b1, 1'b0, 1'b0, 7'h33});
    drive(1, 16'({2'b11, 1'b1, 7'h33, 1'b0}), 11, BB);
    tick(4);
    clr_b();
    a_loop = 0;
    qa.push_back({1'b0, 1'b1, 8'h3C});
    drive(0, 16'({1'b0, 8'h3C, 1'b0}), 10, BA);
    tick(4);
    clr_a();
    a_loop = 1;
    send_a(8'h11, 1);
    send_a(8'h22, 0);
    chk("a_overrun_set", 32'(a_ovr), 1);
    chk("a_overrun_keeps_data", 32'(a_rxd), 32'h11);
    chk("a_overrun_rdy", 32'(a_rdy), 1);
    clr_a();
    chk("a_flags_cleared", 32'({a_perr, a_ferr, a_ovr}), 0);
    a_loop = 0;
    a_drv  = 0;
    tick(BA / 4);
    a_drv = 1;
    tick(3 * BA);
    chk("a_false_start_rdy", 32'(a_rdy), 0);
    chk("a_false_start_idle", 32'(u_a.r_rx_st), 32'(RX_IDLE));
    a_loop = 1;
    send_a(8'hA5, 1);
    tick(2);
    clr_a();
    @(negedge clk);
    a_trmt = 1;
    a_txd  = 8'hC3;
    @(negedge clk);
    a_trmt = 0;
    tick(100);
    rst = 1;
    @(negedge clk);
    chk("a_tx_after_rst", 32'(a_tx), 1);
    chk("a_done_after_rst", 32'(a_done), 0);
    rst = 0;
    tick(3 * BA);
    chk("a_rdy_after_rst", 32'(a_rdy), 0);
    send_a(8'hC3, 1);
    tick(2);
    clr_a();
    tick(4);
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
